// File: rtl/dice_roll_capture.sv
// Debounces per-frame colour detector results into one confirmed dice roll per turn,
// hands it to the game FSM over valid/ready and flags turn end once the board is white again.
module dice_roll_capture #(
   parameter int unsigned STABLE_FRAMES = 3,
   parameter int unsigned CLEAR_FRAMES  = 3,
   parameter logic [15:0] MIN_CONF      = 16'd200,
   parameter int unsigned CNT_W         = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_start,
   input  logic        color_valid,
   input  logic [1:0]  dominant_color,
   input  logic        white_detected,
   input  logic [15:0] color_confidence,
   output logic        roll_valid,
   input  logic        roll_ready,
   output logic [1:0]  roll_steps,
   output logic [1:0]  roll_color,
   output logic        turn_done,
   output logic [1:0]  state_dbg
);

   typedef enum logic [1:0] {
      ST_ARMED      = 2'b00,
      ST_CONFIRM    = 2'b01,
      ST_REPORT     = 2'b10,
      ST_WAIT_CLEAR = 2'b11
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_FRAMES);
   localparam logic [CNT_W-1:0] CLEAR_CNT  = CNT_W'(CLEAR_FRAMES);

   state_t           state_r;
   logic [CNT_W-1:0] cnt_r;
   logic [1:0]       cand_r;
   logic             fs_d1_r;
   logic             fs_d2_r;
   logic             roll_valid_r;
   logic [1:0]       roll_steps_r;
   logic [1:0]       roll_color_r;
   logic             turn_done_r;

   logic             tick_s;
   logic             col_s;
   logic             wht_s;
   logic             same_s;
   logic [CNT_W-1:0] cnt_inc_s;

   // Counters hold at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   function automatic logic is_colour(input logic       valid,
                                      input logic [1:0] colour,
                                      input logic [15:0] conf);
      return valid && (colour != 2'b00) && (conf >= MIN_CONF);
   endfunction

   // Frame tick detection and per-tick classification of the detector pulses.
   always_comb begin
      tick_s    = fs_d1_r & ~fs_d2_r;
      col_s     = is_colour(color_valid, dominant_color, color_confidence);
      cnt_inc_s = sat_inc(cnt_r);
      if (white_detected && !col_s) begin
         wht_s = 1'b1;
      end else begin
         wht_s = 1'b0;
      end
      if (col_s && (dominant_color == cand_r)) begin
         same_s = 1'b1;
      end else begin
         same_s = 1'b0;
      end
   end

   // Turn sequencing FSM with registered handshake and status outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r      <= ST_ARMED;
         cnt_r        <= CNT_ZERO;
         cand_r       <= 2'b00;
         fs_d1_r      <= 1'b0;
         fs_d2_r      <= 1'b0;
         roll_valid_r <= 1'b0;
         roll_steps_r <= 2'b00;
         roll_color_r <= 2'b00;
         turn_done_r  <= 1'b0;
      end else begin
         fs_d1_r     <= frame_start;
         fs_d2_r     <= fs_d1_r;
         turn_done_r <= 1'b0;
         case (state_r)
            ST_ARMED: begin
               if (tick_s && col_s && enable) begin
                  cand_r <= dominant_color;
                  if (CNT_ONE >= STABLE_CNT) begin
                     state_r      <= ST_REPORT;
                     cnt_r        <= CNT_ZERO;
                     roll_valid_r <= 1'b1;
                     roll_steps_r <= dominant_color;
                     roll_color_r <= dominant_color;
                  end else begin
                     state_r <= ST_CONFIRM;
                     cnt_r   <= CNT_ONE;
                  end
               end
            end
            ST_CONFIRM: begin
               // Dropping enable aborts the candidate even on a confirming tick.
               if (!enable) begin
                  state_r <= ST_ARMED;
                  cnt_r   <= CNT_ZERO;
               end else if (tick_s) begin
                  if (same_s) begin
                     if (cnt_inc_s >= STABLE_CNT) begin
                        state_r      <= ST_REPORT;
                        cnt_r        <= CNT_ZERO;
                        roll_valid_r <= 1'b1;
                        roll_steps_r <= cand_r;
                        roll_color_r <= cand_r;
                     end else begin
                        cnt_r <= cnt_inc_s;
                     end
                  end else if (col_s) begin
                     cand_r <= dominant_color;
                     cnt_r  <= CNT_ONE;
                  end else begin
                     state_r <= ST_ARMED;
                     cnt_r   <= CNT_ZERO;
                  end
               end
            end
            ST_REPORT: begin
               if (roll_valid_r && roll_ready) begin
                  state_r      <= ST_WAIT_CLEAR;
                  cnt_r        <= CNT_ZERO;
                  roll_valid_r <= 1'b0;
               end
            end
            ST_WAIT_CLEAR: begin
               if (tick_s) begin
                  if (wht_s) begin
                     if (cnt_inc_s >= CLEAR_CNT) begin
                        state_r     <= ST_ARMED;
                        cnt_r       <= CNT_ZERO;
                        turn_done_r <= 1'b1;
                     end else begin
                        cnt_r <= cnt_inc_s;
                     end
                  end else begin
                     cnt_r <= CNT_ZERO;
                  end
               end
            end
            default: begin
               state_r      <= ST_ARMED;
               cnt_r        <= CNT_ZERO;
               roll_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign roll_valid = roll_valid_r;
   assign roll_steps = roll_steps_r;
   assign roll_color = roll_color_r;
   assign turn_done  = turn_done_r;
   assign state_dbg  = state_r;

endmodule
